// File: rtl/dds_pkg.sv
// dds_pkg: shared defaults, lane-count helper and lane-packed phase type for the DDS phase generator
package dds_pkg;
  localparam int DDS_SPC = 16;
  localparam int DDS_PHASE_WIDTH = 48;
  localparam int DDS_OUT_WIDTH = 16;
  localparam int PHASE_OFFSET_SHIFT = 34;
  function automatic int log2_spc(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 5; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  localparam int LOG2_SPC = log2_spc(DDS_SPC);
  typedef logic [DDS_SPC-1:0][DDS_OUT_WIDTH-1:0] phase_lanes_t;
endpackage

// File: rtl/dds_phase_gen_if.sv
// dds_phase_gen_if: lane-packed phase stream plus delay-matched amplitude words toward the RFDC
interface dds_phase_gen_if #(
  parameter int DW = 256,
  parameter int AW = 14
);
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic [AW-1:0] amp_out;
  logic [AW-1:0] amp_offset_out;
  modport master (output m_axis_tdata, m_axis_tvalid, amp_out, amp_offset_out);
  modport slave  (input  m_axis_tdata, m_axis_tvalid, amp_out, amp_offset_out);
endinterface

// File: rtl/dds_lane_step_table.sv
// dds_lane_step_table: registered k*f per lane built from shifts and adds, fed from the raw freq word so it lines up with the captured freq
module dds_lane_step_table #(
  parameter int N = 16,
  parameter int W = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        f,
  output logic [N-1:0][W-1:0] step_q
);
  logic [N-1:0][W-1:0] step_d;
  function automatic logic [W-1:0] shift_add(input logic [W-1:0] x, input int k);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < 5; b++) if (k[b]) r = r + (x << b);
    return r;
  endfunction
  always_comb begin
    step_d = '0;
    for (int k = 0; k < N; k++) step_d[k] = shift_add(f, k);
  end
  always_ff @(posedge clk)
    if (rst) step_q <= '0;
    else step_q <= step_d;
endmodule

// File: rtl/dds_phase_gen.sv
// dds_phase_gen: phase-continuous multi-lane phase accumulator, three register stages from input to RFDC word
module dds_phase_gen
  import dds_pkg::*;
#(
  parameter int SAMPLES_PER_CYCLE = DDS_SPC,
  parameter int PHASE_WIDTH = DDS_PHASE_WIDTH,
  parameter int OUT_PHASE_WIDTH = DDS_OUT_WIDTH,
  parameter int AXIS_DATA_WIDTH = 256
) (
  input  logic                   m00_axis_aclk,
  input  logic                   reset,
  input  logic [PHASE_WIDTH-1:0] freq,
  input  logic [13:0]            phase,
  input  logic [13:0]            amp,
  input  logic [13:0]            amp_offset,
  input  logic                   sync_clear,
  dds_phase_gen_if.master        m
);
  localparam int N = SAMPLES_PER_CYCLE;
  localparam int PW = PHASE_WIDTH;
  localparam int OW = OUT_PHASE_WIDTH;
  localparam int LG = log2_spc(N);
  logic [PW-1:0] f_q, f_d, acc_q, acc_d;
  logic [13:0] p_q, p_d, a_q, a_d, ao_q, ao_d, a1_q, a1_d, ao1_q, ao1_d, a2_q, a2_d, ao2_q, ao2_d;
  logic clr_q, clr_d;
  logic [2:0] v_q, v_d;
  logic [N-1:0][PW-1:0] step_q;
  logic [N-1:0][OW-1:0] lane_q, lane_d;
  logic [AXIS_DATA_WIDTH-1:0] td_q, td_d;
  dds_lane_step_table #(.N(N), .W(PW)) u_step (
    .clk(m00_axis_aclk),
    .rst(reset),
    .f(freq),
    .step_q(step_q)
  );
  // only the top OW bits of each lane sum are kept; truncation, no rounding
  always_comb begin
    f_d = freq;
    p_d = phase;
    a_d = amp;
    ao_d = amp_offset;
    clr_d = sync_clear;
    acc_d = clr_q ? '0 : acc_q + (f_q << LG);
    lane_d = '0;
    for (int k = 0; k < N; k++)
      lane_d[k] = OW'(((clr_q ? '0 : acc_q) + step_q[k] + (PW'(p_q) << PHASE_OFFSET_SHIFT)) >> (PW - OW));
    td_d = lane_q;
    a1_d = a_q;
    ao1_d = ao_q;
    a2_d = a1_q;
    ao2_d = ao1_q;
    v_d = {v_q[1:0], 1'b1};
  end
  always_ff @(posedge m00_axis_aclk)
    if (reset) begin
      f_q <= '0;
      p_q <= '0;
      a_q <= '0;
      ao_q <= '0;
      clr_q <= 1'b0;
      acc_q <= '0;
      lane_q <= '0;
      a1_q <= '0;
      ao1_q <= '0;
      td_q <= '0;
      a2_q <= '0;
      ao2_q <= '0;
      v_q <= '0;
    end else begin
      f_q <= f_d;
      p_q <= p_d;
      a_q <= a_d;
      ao_q <= ao_d;
      clr_q <= clr_d;
      acc_q <= acc_d;
      lane_q <= lane_d;
      a1_q <= a1_d;
      ao1_q <= ao1_d;
      td_q <= td_d;
      a2_q <= a2_d;
      ao2_q <= ao2_d;
      v_q <= v_d;
    end
  assign m.m_axis_tdata = td_q;
  assign m.m_axis_tvalid = v_q[2];
  assign m.amp_out = a2_q;
  assign m.amp_offset_out = ao2_q;
endmodule

// File: tb/tb_dds_phase_gen.sv
// tb_dds_phase_gen: directed scenarios for the DDS phase generator with hand-derived lane words
module tb_dds_phase_gen;
  import dds_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [47:0] freq = '0;
  logic [13:0] phase = '0, amp = '0, amp_offset = '0;
  logic sync_clear = 1'b0;
  int errors = 0;
  int checks = 0;
  dds_phase_gen_if bus ();
  dds_phase_gen dut (
    .m00_axis_aclk(clk),
    .reset(reset),
    .freq(freq),
    .phase(phase),
    .amp(amp),
    .amp_offset(amp_offset),
    .sync_clear(sync_clear),
    .m(bus)
  );
  always #5 clk = ~clk;
  function automatic phase_lanes_t ramp(input logic [15:0] base, input logic [15:0] inc);
    phase_lanes_t r;
    for (int k = 0; k < 16; k++) r[k] = base + 16'(k) * inc;
    return r;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    phase_lanes_t w;
    reset = 1'b1;
    tick(5);
    checks += 4;
    if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", bus.m_axis_tvalid); end
    if (bus.m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", bus.m_axis_tdata); end
    if (bus.amp_out !== '0) begin errors++; $display("FAIL reset_amp: got %h want 0", bus.amp_out); end
    if (bus.amp_offset_out !== '0) begin errors++; $display("FAIL reset_ampoff: got %h want 0", bus.amp_offset_out); end
    reset = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      checks++;
      if (bus.m_axis_tvalid !== (e == 3)) begin errors++; $display("FAIL fill_tvalid edge %0d: got %b want %b", e, bus.m_axis_tvalid, e == 3); end
    end
    w = bus.m_axis_tdata;
    checks++;
    if (w !== '0) begin errors++; $display("FAIL fill_tdata: got %h want 0", w); end
  endtask
  task automatic test_quarter_wrap;
    phase_lanes_t exp;
    exp = ramp(16'h0000, 16'd4096);
    freq = 48'h1 << 44;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.m_axis_tdata !== exp) begin errors++; $display("FAIL quarter_wrap cycle %0d: got %h want %h", i, bus.m_axis_tdata, exp); end
      tick(1);
    end
  endtask
  task automatic test_phase_offset;
    phase_lanes_t e1, e2;
    e1 = ramp(16'h4000, 16'h0);
    e2 = ramp(16'hFFFC, 16'h0);
    freq = '0;
    phase = 14'h1000;
    tick(3);
    checks++;
    if (bus.m_axis_tdata !== e1) begin errors++; $display("FAIL phase_1000: got %h want %h", bus.m_axis_tdata, e1); end
    phase = 14'h3FFF;
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      checks++;
      if (bus.m_axis_tdata !== (e == 3 ? e2 : e1)) begin errors++; $display("FAIL phase_3fff edge %0d: got %h want %h", e, bus.m_axis_tdata, e == 3 ? e2 : e1); end
    end
  endtask
  task automatic test_continuity;
    logic [15:0] prev, l0, l1;
    logic [15:0] inc0 [4] = '{16'd4096, 16'd4096, 16'd4096, 16'd8192};
    logic [15:0] inc1 [4] = '{16'd256, 16'd256, 16'd512, 16'd512};
    phase = '0;
    freq = 48'h1 << 40;
    tick(4);
    prev = bus.m_axis_tdata[15:0];
    for (int i = 0; i < 9; i++) begin
      tick(1);
      l0 = bus.m_axis_tdata[15:0];
      l1 = bus.m_axis_tdata[31:16];
      checks += 2;
      if (l0 !== prev + 16'd4096) begin errors++; $display("FAIL cont_old lane0 cycle %0d: got %h want %h", i, l0, prev + 16'd4096); end
      if (l1 !== l0 + 16'd256) begin errors++; $display("FAIL cont_old lane1 cycle %0d: got %h want %h", i, l1, l0 + 16'd256); end
      prev = l0;
    end
    freq = 48'h1 << 41;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      l0 = bus.m_axis_tdata[15:0];
      l1 = bus.m_axis_tdata[31:16];
      checks += 2;
      if (l0 !== prev + inc0[i]) begin errors++; $display("FAIL cont_new lane0 cycle %0d: got %h want %h", i, l0, prev + inc0[i]); end
      if (l1 !== l0 + inc1[i]) begin errors++; $display("FAIL cont_new lane1 cycle %0d: got %h want %h", i, l1, l0 + inc1[i]); end
      prev = l0;
    end
  endtask
  task automatic test_sync_clear;
    phase_lanes_t e1, e2;
    e1 = ramp(16'h0000, 16'd4096);
    e2 = ramp(16'h0000, 16'd512);
    freq = 48'h1 << 44;
    sync_clear = 1'b1;
    tick(1);
    sync_clear = 1'b0;
    tick(2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.m_axis_tdata !== e1) begin errors++; $display("FAIL clear_freq cycle %0d: got %h want %h", i, bus.m_axis_tdata, e1); end
      tick(1);
    end
    freq = 48'h1 << 41;
    sync_clear = 1'b1;
    tick(3);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.m_axis_tdata !== e2) begin errors++; $display("FAIL clear_held cycle %0d: got %h want %h", i, bus.m_axis_tdata, e2); end
      tick(1);
    end
    sync_clear = 1'b0;
  endtask
  task automatic test_mid_reset;
    phase_lanes_t e1;
    e1 = ramp(16'h0000, 16'd4096);
    freq = 48'h1 << 44;
    phase = '0;
    amp = 14'h1234;
    amp_offset = 14'h0ABC;
    tick(3);
    checks += 2;
    if (bus.amp_out !== 14'h1234) begin errors++; $display("FAIL run_amp: got %h want 1234", bus.amp_out); end
    if (bus.amp_offset_out !== 14'h0ABC) begin errors++; $display("FAIL run_ampoff: got %h want 0abc", bus.amp_offset_out); end
    reset = 1'b1;
    tick(1);
    checks += 4;
    if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b want 0", bus.m_axis_tvalid); end
    if (bus.m_axis_tdata !== '0) begin errors++; $display("FAIL midrst_tdata: got %h want 0", bus.m_axis_tdata); end
    if (bus.amp_out !== '0) begin errors++; $display("FAIL midrst_amp: got %h want 0", bus.amp_out); end
    if (bus.amp_offset_out !== '0) begin errors++; $display("FAIL midrst_ampoff: got %h want 0", bus.amp_offset_out); end
    tick(1);
    reset = 1'b0;
    tick(2);
    checks += 2;
    if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL refill_tvalid edge2: got %b want 0", bus.m_axis_tvalid); end
    if (bus.amp_out !== '0) begin errors++; $display("FAIL refill_amp edge2: got %h want 0", bus.amp_out); end
    tick(1);
    checks += 4;
    if (bus.m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL refill_tvalid edge3: got %b want 1", bus.m_axis_tvalid); end
    if (bus.amp_out !== 14'h1234) begin errors++; $display("FAIL refill_amp edge3: got %h want 1234", bus.amp_out); end
    if (bus.amp_offset_out !== 14'h0ABC) begin errors++; $display("FAIL refill_ampoff edge3: got %h want 0abc", bus.amp_offset_out); end
    if (bus.m_axis_tdata !== e1) begin errors++; $display("FAIL refill_tdata: got %h want %h", bus.m_axis_tdata, e1); end
  endtask
  initial begin
    test_reset();
    test_quarter_wrap();
    test_phase_offset();
    test_continuity();
    test_sync_clear();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end
endmodule
